// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product stream in, dot-product result stream out
interface product_accumulator_if #(
  parameter int PRODUCT_WIDTH = 16,
  parameter int ACC_WIDTH     = 24,
  parameter int CNT_WIDTH     = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [PRODUCT_WIDTH-1:0] in_product;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_WIDTH-1:0]     out_sum;
  logic [CNT_WIDTH-1:0]     out_count;
  logic                     out_overflow;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - streaming dot-product accumulator with a single-entry result buffer
// Sums unsigned products until a last beat, then hands sum/count/overflow to the output registers.
module product_accumulator #(
  parameter int INPUT_WIDTH   = 8,
  parameter int PRODUCT_WIDTH = 2 * INPUT_WIDTH,
  parameter int ACC_WIDTH     = 24,
  parameter int CNT_WIDTH     = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  product_accumulator_if.slave bus
);

  if (ACC_WIDTH < PRODUCT_WIDTH || PRODUCT_WIDTH < INPUT_WIDTH) begin : g_bad_widths
    $error("product_accumulator: ACC_WIDTH must be >= PRODUCT_WIDTH >= INPUT_WIDTH");
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;

  logic                 accept;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 ovf_next;

  // Single-entry output buffer: a new beat may enter whenever the result slot frees this cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign sum_ext  = {1'b0, acc} + {{(ACC_WIDTH + 1 - PRODUCT_WIDTH){1'b0}}, bus.in_product};
  assign acc_next = sum_ext[ACC_WIDTH-1:0];
  assign ovf_next = ovf | sum_ext[ACC_WIDTH];
  assign cnt_next = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc              <= '0;
      cnt              <= '0;
      ovf              <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_sum      <= '0;
      bus.out_count    <= '0;
      bus.out_overflow <= 1'b0;
    end else begin
      if (accept && bus.in_last) begin
        bus.out_sum      <= acc_next;
        bus.out_count    <= cnt_next;
        bus.out_overflow <= ovf_next;
        bus.out_valid    <= 1'b1;
        acc              <= '0;
        cnt              <= '0;
        ovf              <= 1'b0;
      end else begin
        if (accept) begin
          acc <= acc_next;
          cnt <= cnt_next;
          ovf <= ovf_next;
        end
        if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator
module tb_product_accumulator;

  typedef struct packed {
    logic [23:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  product_accumulator_if #(.PRODUCT_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) bus ();
  product_accumulator_if #(.PRODUCT_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) bus2 ();

  product_accumulator #(.INPUT_WIDTH(8), .PRODUCT_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  product_accumulator #(.INPUT_WIDTH(8), .PRODUCT_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  int   total = 0;
  int   bad = 0;
  int   timeouts = 0;
  exp_t sb1[$];
  exp_t sb2[$];
  exp_t e;

  function automatic exp_t mk(input logic [23:0] s, input logic [7:0] c, input logic o);
    exp_t r;
    r.sum = s;
    r.cnt = c;
    r.ovf = o;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat on dut and waits (bounded) for it to be accepted.
  task automatic send(input logic [15:0] p, input logic l);
    bit ok;
    ok = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    bus.in_last    = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!ok) timeouts++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 0;  bus.in_product = 0;  bus.in_last = 0;  bus.out_ready = 1;
    bus2.in_valid = 0; bus2.in_product = 0; bus2.in_last = 0; bus2.out_ready = 1;
    #12;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 24'd0 || bus.out_count !== 8'd0 || bus.out_overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b sum=%0d cnt=%0d ovf=%b want all 0",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_overflow);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send(16'd15, 1'b0);
    send(16'd0, 1'b0);
    sb1.push_back(mk(24'd57, 8'd3, 1'b0));
    send(16'd42, 1'b1);
    e = sb1.pop_front();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_count !== e.cnt || bus.out_overflow !== e.ovf) begin
      bad++;
      $display("FAIL basic_result: got v=%b sum=%0d cnt=%0d ovf=%b want v=1 sum=%0d cnt=%0d ovf=%b",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_overflow, e.sum, e.cnt, e.ovf);
    end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b1;
    sb1.push_back(mk(24'd64259, 8'd255, 1'b1));
    for (int i = 1; i <= 259; i++) send(16'd65025, i == 259);
    e = sb1.pop_front();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_count !== e.cnt || bus.out_overflow !== e.ovf) begin
      bad++;
      $display("FAIL overflow_result: got v=%b sum=%0d cnt=%0d ovf=%b want v=1 sum=%0d cnt=%0d ovf=%b",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_overflow, e.sum, e.cnt, e.ovf);
    end
    sb1.push_back(mk(24'd1, 8'd1, 1'b0));
    send(16'd1, 1'b1);
    e = sb1.pop_front();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_count !== e.cnt || bus.out_overflow !== e.ovf) begin
      bad++;
      $display("FAIL overflow_cleared: got v=%b sum=%0d cnt=%0d ovf=%b want v=1 sum=%0d cnt=%0d ovf=%b",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_overflow, e.sum, e.cnt, e.ovf);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    send(16'd5, 1'b0);
    sb1.push_back(mk(24'd8, 8'd2, 1'b0));
    send(16'd3, 1'b1);
    bus.in_valid = 1'b1; bus.in_product = 16'd100; bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_sum !== 24'd8) begin
        bad++;
        $display("FAIL stall_cycle%0d: got rdy=%b v=%b sum=%0d want rdy=0 v=1 sum=8",
                 i, bus.in_ready, bus.out_valid, bus.out_sum);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    e = sb1.pop_front();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_count !== e.cnt) begin
      bad++;
      $display("FAIL stall_release: got rdy=%b v=%b sum=%0d cnt=%0d want rdy=1 v=1 sum=%0d cnt=%0d",
               bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count, e.sum, e.cnt);
    end
    sb1.push_back(mk(24'd100, 8'd1, 1'b0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    e = sb1.pop_front();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_count !== e.cnt || bus.out_overflow !== e.ovf) begin
      bad++;
      $display("FAIL stalled_beat_accepted: got v=%b sum=%0d cnt=%0d ovf=%b want v=1 sum=%0d cnt=%0d ovf=%b",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_overflow, e.sum, e.cnt, e.ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    vals[0] = 16'd7; vals[1] = 16'd9; vals[2] = 16'd11;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb1.push_back(mk(24'(vals[i]), 8'd1, 1'b0));
      send(vals[i], 1'b1);
      e = sb1.pop_front();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_count !== e.cnt) begin
        bad++;
        $display("FAIL b2b_%0d: got v=%b sum=%0d cnt=%0d want v=1 sum=%0d cnt=%0d",
                 i, bus.out_valid, bus.out_sum, bus.out_count, e.sum, e.cnt);
      end
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 24'd11) begin
      bad++;
      $display("FAIL b2b_drain: got v=%b sum=%0d want v=0 sum=11", bus.out_valid, bus.out_sum);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    send(16'd200, 1'b0);
    send(16'd300, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 24'd0 || bus.out_count !== 8'd0 || bus.out_overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got v=%b sum=%0d cnt=%0d ovf=%b want all 0",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_overflow);
    end
    #2;
    rst_n = 1'b1;
    tick();
    sb1.push_back(mk(24'd4, 8'd1, 1'b0));
    send(16'd4, 1'b1);
    e = sb1.pop_front();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_count !== e.cnt || bus.out_overflow !== e.ovf) begin
      bad++;
      $display("FAIL reset_mid_next: got v=%b sum=%0d cnt=%0d ovf=%b want v=1 sum=%0d cnt=%0d ovf=%b",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_overflow, e.sum, e.cnt, e.ovf);
    end
  endtask

  // Two accumulators fed by multiplier models with 3- and 9-cycle latency.
  task automatic test_integration();
    logic [7:0]  a_arr [30];
    logic [7:0]  b_arr [30];
    logic        l_arr [30];
    logic [24:0] s1, s2;
    logic [7:0]  c1, c2;
    logic        o1, o2;
    logic [15:0] prod;
    int          rem, i1, i2;
    rem = $urandom_range(1, 8);
    for (int i = 0; i < 30; i++) begin
      a_arr[i] = 8'($urandom);
      b_arr[i] = 8'($urandom);
      rem--;
      l_arr[i] = (rem == 0) || (i == 29);
      if (rem == 0) rem = $urandom_range(1, 8);
    end
    s1 = '0; s2 = '0; c1 = '0; c2 = '0; o1 = 1'b0; o2 = 1'b0;
    bus.out_ready = 1'b1; bus2.out_ready = 1'b1;
    tick();
    for (int t = 0; t < 42; t++) begin
      i1 = t - 3;
      i2 = t - 9;
      bus.in_valid = 1'b0;
      bus2.in_valid = 1'b0;
      if (i1 >= 0 && i1 < 30) begin
        prod = 16'(a_arr[i1]) * 16'(b_arr[i1]);
        bus.in_valid = 1'b1; bus.in_product = prod; bus.in_last = l_arr[i1];
        s1 = s1 + 25'(prod); o1 = o1 | s1[24]; s1[24] = 1'b0;
        if (c1 != 8'hff) c1 = c1 + 8'd1;
        if (l_arr[i1]) begin
          sb1.push_back(mk(s1[23:0], c1, o1));
          s1 = '0; c1 = '0; o1 = 1'b0;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
          bad++;
          $display("FAIL integ_ready_lat3: t=%0d got %b want 1", t, bus.in_ready);
        end
      end
      if (i2 >= 0 && i2 < 30) begin
        prod = 16'(a_arr[i2]) * 16'(b_arr[i2]);
        bus2.in_valid = 1'b1; bus2.in_product = prod; bus2.in_last = l_arr[i2];
        s2 = s2 + 25'(prod); o2 = o2 | s2[24]; s2[24] = 1'b0;
        if (c2 != 8'hff) c2 = c2 + 8'd1;
        if (l_arr[i2]) begin
          sb2.push_back(mk(s2[23:0], c2, o2));
          s2 = '0; c2 = '0; o2 = 1'b0;
        end
      end
      tick();
      if (bus.out_valid) begin
        total++;
        if (sb1.size() == 0) begin
          bad++;
          $display("FAIL integ_lat3_extra: got sum=%0d want no result", bus.out_sum);
        end else begin
          e = sb1.pop_front();
          if (bus.out_sum !== e.sum || bus.out_count !== e.cnt || bus.out_overflow !== e.ovf) begin
            bad++;
            $display("FAIL integ_lat3: got sum=%0d cnt=%0d ovf=%b want sum=%0d cnt=%0d ovf=%b",
                     bus.out_sum, bus.out_count, bus.out_overflow, e.sum, e.cnt, e.ovf);
          end
        end
      end
      if (bus2.out_valid) begin
        total++;
        if (sb2.size() == 0) begin
          bad++;
          $display("FAIL integ_lat9_extra: got sum=%0d want no result", bus2.out_sum);
        end else begin
          e = sb2.pop_front();
          if (bus2.out_sum !== e.sum || bus2.out_count !== e.cnt || bus2.out_overflow !== e.ovf) begin
            bad++;
            $display("FAIL integ_lat9: got sum=%0d cnt=%0d ovf=%b want sum=%0d cnt=%0d ovf=%b",
                     bus2.out_sum, bus2.out_count, bus2.out_overflow, e.sum, e.cnt, e.ovf);
          end
        end
      end
    end
    total++;
    if (sb1.size() != 0 || sb2.size() != 0) begin
      bad++;
      $display("FAIL integ_missing: got pending lat3=%0d lat9=%0d want 0 0", sb1.size(), sb2.size());
    end
  endtask

  task automatic test_handshake_timeouts();
    total++;
    if (timeouts != 0) begin
      bad++;
      $display("FAIL send_timeouts: got %0d want 0", timeouts);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_integration();
    test_handshake_timeouts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
